// File: rtl/instr_dcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_dcd_pkg
// Description : Shared types and constants for the burst instruction decoder:
//               FSM state encoding, header bit positions, register address
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_dcd_pkg;

   // Width of the register file address bus
   localparam int REG_ADDR_W    = 6;

   // Header byte layout: [7] direction, [6] burst, [5:0] start address
   localparam int HDR_DIR_BIT   = 7;
   localparam int HDR_BURST_BIT = 6;
   localparam int HDR_ADDR_MSB  = 5;

   // Decoder FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEN  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_dcd_timeout.sv
`default_nettype none
// ============================================================================
// Module      : instr_dcd_timeout
// Description : Inter-byte watchdog. Counts enabled cycles, restarts on clear,
//               and raises a one-cycle pulse on the TIMEOUT_CYC-th cycle
//               without a clear. Only instantiated when INSTR_DCD_TIMEOUT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_dcd_timeout #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic timeout_o
);

   localparam int                 c_CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic [c_CNT_W-1:0] cnt_q;
   logic [c_CNT_W-1:0] cnt_d;

   // Pulse on the last silent cycle so the consumer leaves its state on the
   // TIMEOUT_CYC-th edge after the most recent clear
   assign timeout_o = en_i && !clr_i && (cnt_q == c_LAST);

   // Next count: restart on clear, when idle, or once the timeout has fired
   always_comb begin
      cnt_d = cnt_q + c_ONE;
      if (clr_i || !en_i || timeout_o) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_dcd_burst.sv
`default_nettype none
// ============================================================================
// Module      : instr_dcd_burst
// Description : SPI instruction decoder with burst support. Decodes a header
//               byte, an optional burst length byte and N data bytes, and
//               issues one-cycle register read/write strobes with
//               auto-incrementing addresses, range checking and a sticky
//               error flag.
//               Optional macro INSTR_DCD_TIMEOUT_EN adds an inter-byte
//               timeout that aborts a stalled transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_dcd_burst
   import instr_dcd_pkg::*;
#(
   parameter logic [REG_ADDR_W-1:0] ADDR_LIMIT  = 6'h0F,
   parameter int                    MAX_BURST   = 16,
   parameter int                    TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  byte_sync_i,
   input  logic [7:0]            data_in_i,
   output logic [7:0]            data_out_o,
   output logic                  read_o,
   output logic                  write_o,
   output logic [REG_ADDR_W-1:0] addr_o,
   input  logic [7:0]            data_read_i,
   output logic [7:0]            data_write_o,
   output logic                  busy_o,
   output logic                  err_o,
   input  logic                  err_clr_i
);

   localparam logic [7:0]            c_MAX_BURST = 8'(MAX_BURST);
   localparam logic [REG_ADDR_W-1:0] c_ADDR_ONE  = REG_ADDR_W'(1);

   state_t                  state_q,      state_d;
   logic                    dir_q,        dir_d;        // 1 = write transaction
   logic [REG_ADDR_W-1:0]   addr_q,       addr_d;
   logic [7:0]              rem_q,        rem_d;        // data bytes still expected
   logic                    rd_pend_q,    rd_pend_d;    // prefetch read due next edge
   logic                    wr_pend_q,    wr_pend_d;    // write strobe due next edge
   logic                    inc_pend_q,   inc_pend_d;   // post-write address step
   logic                    read_q,       read_d;
   logic                    write_q,      write_d;
   logic [7:0]              data_out_q,   data_out_d;
   logic [7:0]              data_write_q, data_write_d;
   logic                    err_q,        err_d;

   logic                    w_addr_oor;
   logic                    w_err_set;
   logic                    w_timeout;

   assign w_addr_oor = (addr_q > ADDR_LIMIT);

`ifdef INSTR_DCD_TIMEOUT_EN
   instr_dcd_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (state_q != ST_IDLE),
      .clr_i     (byte_sync_i),
      .timeout_o (w_timeout)
   );
`else
   // Watchdog absent: a stalled transaction waits for more bytes forever.
   // The expression is constant false; it keeps TIMEOUT_CYC referenced.
   assign w_timeout = (TIMEOUT_CYC < 0);
`endif

   // Next-state, strobe and datapath decode; pending strobes are serviced
   // before the incoming byte so a coincident byte is still handled
   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      rd_pend_d    = 1'b0;
      wr_pend_d    = 1'b0;
      inc_pend_d   = 1'b0;
      read_d       = 1'b0;
      write_d      = 1'b0;
      data_out_d   = data_out_q;
      data_write_d = data_write_q;
      w_err_set    = 1'b0;

      // Prefetch read: capture register data alongside the strobe
      if (rd_pend_q) begin
         if (w_addr_oor) begin
            data_out_d = 8'h00;
            w_err_set  = 1'b1;
         end else begin
            read_d     = 1'b1;
            data_out_d = data_read_i;
         end
      end

      // Write strobe, followed by an address step one cycle later
      if (wr_pend_q) begin
         if (w_addr_oor) begin
            w_err_set = 1'b1;
         end else begin
            write_d = 1'b1;
         end
         inc_pend_d = 1'b1;
      end

      if (inc_pend_q) begin
         addr_d = addr_q + c_ADDR_ONE;
      end

      if (byte_sync_i) begin
         case (state_q)
            ST_IDLE: begin
               dir_d  = data_in_i[HDR_DIR_BIT];
               addr_d = data_in_i[HDR_ADDR_MSB:0];
               if (data_in_i[HDR_BURST_BIT]) begin
                  state_d = ST_LEN;
               end else begin
                  rem_d     = 8'd1;
                  state_d   = ST_DATA;
                  rd_pend_d = !data_in_i[HDR_DIR_BIT];
               end
            end
            ST_LEN: begin
               if (data_in_i == 8'd0) begin
                  w_err_set = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  if (data_in_i > c_MAX_BURST) begin
                     rem_d     = c_MAX_BURST;
                     w_err_set = 1'b1;
                  end else begin
                     rem_d = data_in_i;
                  end
                  state_d   = ST_DATA;
                  rd_pend_d = !dir_q;
               end
            end
            ST_DATA: begin
               rem_d = rem_q - 8'd1;
               if (dir_q) begin
                  data_write_d = data_in_i;
                  wr_pend_d    = 1'b1;
               end else if (rem_q > 8'd1) begin
                  addr_d    = addr_q + c_ADDR_ONE;
                  rd_pend_d = 1'b1;
               end
               if (rem_q <= 8'd1) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Abort a stalled transaction and drop anything still in flight
      if (w_timeout) begin
         state_d    = ST_IDLE;
         read_d     = 1'b0;
         write_d    = 1'b0;
         rd_pend_d  = 1'b0;
         wr_pend_d  = 1'b0;
         inc_pend_d = 1'b0;
         w_err_set  = 1'b1;
      end

      // Sticky error: a new error event overrides a clear in the same cycle
      if (w_err_set) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State and datapath registers; reset drops any pending strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dir_q        <= 1'b0;
         addr_q       <= '0;
         rem_q        <= 8'd0;
         rd_pend_q    <= 1'b0;
         wr_pend_q    <= 1'b0;
         inc_pend_q   <= 1'b0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         data_out_q   <= 8'h00;
         data_write_q <= 8'h00;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         rd_pend_q    <= rd_pend_d;
         wr_pend_q    <= wr_pend_d;
         inc_pend_q   <= inc_pend_d;
         read_q       <= read_d;
         write_q      <= write_d;
         data_out_q   <= data_out_d;
         data_write_q <= data_write_d;
         err_q        <= err_d;
      end
   end

   assign data_out_o   = data_out_q;
   assign read_o       = read_q;
   assign write_o      = write_q;
   assign addr_o       = addr_q;
   assign data_write_o = data_write_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign err_o        = err_q;

endmodule
`default_nettype wire
